lc3_mem_responder: RTL and testbench
====================================

# lc3_mem_responder

Memory-side responder for the LC-3 datapath: it answers the CPU's MAR/MDR memory requests and returns read data to the datapath's MDR input. It contains on-chip word RAM, a programmable wait-state counter and a memory-mapped I/O port at 0xFFFF (switches on read, hex display register on write). It sits between the CPU control FSM/datapath and the board I/O, and replaces direct wiring of memory to the MDR mux.

## Interface
- `DEPTH`, default 1024: number of 16-bit RAM words, covering addresses 0..DEPTH-1. Must be a power of two, ≤ 65535.
- `WAIT_STATES`, default 2: extra cycles inserted before each access completes. Range 0..15.
- `Clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `Reset`: input, 1 bit. Synchronous, active-high.
- `mem_req`: input, 1 bit. Request level from the CPU FSM. Held high until `mem_ready` is seen.
- `mem_we`: input, 1 bit. 1 = write, 0 = read. Sampled with the request.
- `mem_addr`: input, 16 bits. Word address (MAR).
- `mem_wdata`: input, 16 bits. Write data (MDR).
- `SW`: input, 16 bits. Board switches, read at 0xFFFF.
- `mem_rdata`: output, 16 bits. Read data to the datapath MDR input; registered.
- `mem_ready`: output, 1 bit. One-cycle completion pulse.
- `hex_out`: output, 16 bits. Display register, written at 0xFFFF.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE with `mem_req`=1: latch `mem_addr`, `mem_we` and `mem_wdata`.
  - If `WAIT_STATES`=0: perform the access and go to RESP.
  - Otherwise: load `cnt` = `WAIT_STATES`-1 and go to WAIT.
- IDLE with `mem_req`=0: stay in IDLE.
- WAIT with `cnt`=0: perform the access and go to RESP. Otherwise decrement `cnt` and stay in WAIT.
- RESP: `mem_ready`=1 for exactly this cycle, then go unconditionally to IDLE.
- Access uses the latched values only. Input changes after the request is sampled are ignored.
  - Read, addr < DEPTH: `mem_rdata` ← RAM[addr].
  - Read, addr = 0xFFFF: `mem_rdata` ← `SW`, sampled at the access edge.
  - Read, any other addr: `mem_rdata` ← 0.
  - Write, addr < DEPTH: RAM[addr] ← wdata.
  - Write, addr = 0xFFFF: `hex_out` ← wdata.
  - Write, any other addr: ignored. `mem_rdata` is unchanged by any write.
- `mem_rdata` holds its value until the next read completes.
- Requester contract: drop `mem_req` in the cycle after `mem_ready`. If `mem_req` is still high in the IDLE cycle after RESP, a new transaction starts. Back-to-back access is therefore legal.
- Reset (any state): FSM → IDLE, `cnt` → 0, `mem_ready` → 0, `mem_rdata` → 0x0000, `hex_out` → 0x0000.
  - Reset during WAIT aborts the access with no RAM or `hex_out` update.
  - RAM contents are not cleared by reset.

## Timing
- Request high in cycle 0 (sampled at the end of cycle 0): `mem_ready` is high in cycle 1+`WAIT_STATES`. Default: cycle 3.
- `mem_rdata` is valid in the same cycle as `mem_ready` and stays stable afterwards.
- Minimum transaction period: `WAIT_STATES`+2 cycles, because RESP→IDLE costs one cycle.
- Read-after-write to the same address in the next transaction returns the new data.
- `mem_req` low in IDLE has no side effects.
- `mem_we`/`mem_addr` changes outside IDLE have no effect.

## Structure
- Package `lc3_mem_pkg` holds:
  - `mem_state_t` enum {IDLE, WAIT, RESP};
  - `IO_ADDR` = 16'hFFFF;
  - `WORD_W` = 16.
- Sub-module `sp_ram_16`:
  - single-port RAM, parameter `DEPTH`;
  - synchronous write, combinational read.
  - The responder registers the read result into `mem_rdata`.
- The top module holds the FSM, `cnt`, the request latches, address decode and the `hex_out`/`mem_rdata` registers.

## Test plan
- **Reset:** assert `Reset` 2 cycles → `mem_rdata`=0x0000, `hex_out`=0x0000, `mem_ready`=0. Hold `mem_req`=0 for 10 cycles → `mem_ready` never pulses.
- **Write then read, `WAIT_STATES`=2:**
  - write 0xBEEF to 0x0010 → `mem_ready` in cycle 3 only;
  - next read of 0x0010 → `mem_rdata`=0xBEEF with `mem_ready`.
  - Repeat with `WAIT_STATES`=0 → `mem_ready` in cycle 1.
- **I/O port:**
  - `SW`=0x1234, read 0xFFFF → 0x1234;
  - write 0x00A5 to 0xFFFF → `hex_out`=0x00A5;
  - RAM[DEPTH-1] is untouched.
- **Out-of-range, `DEPTH`=1024:**
  - read 0x0400 → `mem_rdata`=0x0000;
  - write 0x5555 to 0x0400, then read 0x0000 → prior contents unchanged.
- **Input stability:** issue read of 0x0010, then change `mem_addr` to 0x0020 during WAIT → returned data is RAM[0x0010].
- **Reset mid-write:** issue write 0xDEAD to 0x0008 (which holds 0x1111), assert `Reset` in the first WAIT cycle → no `mem_ready`; subsequent read of 0x0008 returns 0x1111. Also, holding `mem_req` high through RESP starts a second transaction immediately.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory responder.
package lc3_mem_pkg;

    localparam int          WORD_W  = 16;
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

endpackage

// File: rtl/sp_ram_16.sv
// Single-port 16-bit word RAM: synchronous write, combinational read.
// DEPTH must be a power of two and at least 2.
module sp_ram_16 #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [DEPTH];

    // Write port: the word is stored on the rising edge when we is high.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 datapath: on-chip RAM, programmable
// wait states and a memory-mapped switch/hex-display port at IO_ADDR.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] SW,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic [15:0] hex_out
);

    localparam int          ADDR_W   = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_STATES - 1);
    localparam logic [16:0] DEPTH_W  = 17'(DEPTH);

    mem_state_t  state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        do_access;

    logic [15:0] addr_lat, wdata_lat;
    logic        we_lat;

    logic [15:0] acc_addr, acc_wdata;
    logic        acc_we;
    logic        in_ram, is_io, ram_we;
    logic [15:0] ram_rdata;

    // With zero wait states the access happens on the same edge that samples
    // the request, so the live inputs stand in for the not-yet-latched copies.
    assign acc_addr  = (state == IDLE) ? mem_addr  : addr_lat;
    assign acc_wdata = (state == IDLE) ? mem_wdata : wdata_lat;
    assign acc_we    = (state == IDLE) ? mem_we    : we_lat;

    assign in_ram = ({1'b0, acc_addr} < DEPTH_W);
    assign is_io  = (acc_addr == IO_ADDR);
    assign ram_we = do_access && acc_we && in_ram && !Reset;

    sp_ram_16 #(
        .DEPTH (DEPTH)
    ) u_ram (
        .Clk   (Clk),
        .we    (ram_we),
        .addr  (acc_addr[ADDR_W-1:0]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // State and wait counter registers; reset returns to IDLE from anywhere.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; do_access marks the edge on which the access lands.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    if (WAIT_STATES == 0) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = CNT_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Completion pulse is high for the single RESP cycle.
    always_comb begin
        mem_ready = (state == RESP);
    end

    // Request latches plus the read-data and display registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_lat  <= 16'h0000;
            wdata_lat <= 16'h0000;
            we_lat    <= 1'b0;
            mem_rdata <= 16'h0000;
            hex_out   <= 16'h0000;
        end else begin
            if (state == IDLE && mem_req) begin
                addr_lat  <= mem_addr;
                wdata_lat <= mem_wdata;
                we_lat    <= mem_we;
            end
            if (do_access) begin
                if (acc_we) begin
                    if (is_io) begin
                        hex_out <= acc_wdata;
                    end
                end else if (in_ram) begin
                    mem_rdata <= ram_rdata;
                end else if (is_io) begin
                    mem_rdata <= SW;
                end else begin
                    mem_rdata <= 16'h0000;
                end
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: table vectors, corner-case
// sequences and randomized transactions against a word-level model.
module tb_lc3_mem_responder;

    localparam int DEPTH = 1024;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;

    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [15:0] mem_addr = 16'h0, mem_wdata = 16'h0, sw = 16'h0;
    logic [15:0] mem_rdata, hex_out;
    logic        mem_ready;

    logic        z_req = 1'b0, z_we = 1'b0;
    logic [15:0] z_addr = 16'h0, z_wdata = 16'h0, z_sw = 16'h0;
    logic [15:0] z_rdata, z_hex;
    logic        z_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] ram_m [int];
    logic [15:0] rdata_m = 16'h0;
    logic [15:0] hex_m = 16'h0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic [15:0] exp_rdata;
        logic [15:0] exp_hex;
    } vec_t;

    vec_t vecs[10];

    lc3_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut (
        .Clk(Clk), .Reset(Reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .SW(sw),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hex_out(hex_out)
    );

    lc3_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .mem_req(z_req), .mem_we(z_we),
        .mem_addr(z_addr), .mem_wdata(z_wdata), .SW(z_sw),
        .mem_rdata(z_rdata), .mem_ready(z_ready), .hex_out(z_hex)
    );

    always #5 Clk = ~Clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Word-level reference: what a single completed access does.
    function automatic void model_apply(input logic we, input logic [15:0] addr,
                                        input logic [15:0] wdata, input logic [15:0] swv);
        if (!we) begin
            if (addr < DEPTH)         rdata_m = ram_m[int'(addr)];
            else if (addr == 16'hFFFF) rdata_m = swv;
            else                       rdata_m = 16'h0;
        end else begin
            if (addr < DEPTH)         ram_m[int'(addr)] = wdata;
            else if (addr == 16'hFFFF) hex_m = wdata;
        end
    endfunction

    // One full transaction on either instance; returns latency and outputs.
    task automatic apply_stimulus(input bit sel, input logic we, input logic [15:0] addr,
                                  input logic [15:0] wdata, input logic [15:0] swv,
                                  output int lat, output logic [15:0] rd, output logic [15:0] hx);
        bit got = 0;
        @(posedge Clk); #1;
        if (sel) begin
            z_req = 1; z_we = we; z_addr = addr; z_wdata = wdata; z_sw = swv;
        end else begin
            mem_req = 1; mem_we = we; mem_addr = addr; mem_wdata = wdata; sw = swv;
        end
        lat = 0;
        while (!got && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
            if ((sel ? z_ready : mem_ready) === 1'b1) got = 1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL ready_timeout: got no ready, expected ready within 40 cycles");
        end
        rd = sel ? z_rdata : mem_rdata;
        hx = sel ? z_hex : hex_out;
        if (sel) z_req = 0; else mem_req = 0;
        @(posedge Clk); #1;
        check_output("ready_single_pulse", sel ? z_ready : mem_ready, 0);
        check_output("rdata_hold", sel ? z_rdata : mem_rdata, rd);
    endtask

    function automatic logic [15:0] pick_addr();
        int k = $urandom_range(0, 9);
        if (k <= 5)      return 16'($urandom_range(0, 31));
        else if (k == 6) return 16'h03FF;
        else if (k == 7) return 16'h0400 + 16'($urandom_range(0, 15));
        else if (k == 8) return 16'hFFFF;
        else             return 16'h8000 | 16'($urandom_range(0, 16'h7FFE));
    endfunction

    initial begin
        int lat, t, first, second;
        logic [15:0] rd, hx, a, d, s;
        logic w;
        bit saw;

        vecs[0] = '{1'b1, 16'h0000, 16'h0F0F, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 16'h03FF, 16'h7777, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1234, 16'h1234, 16'h0000};
        vecs[5] = '{1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 16'h1234, 16'h00A5};
        vecs[6] = '{1'b0, 16'h03FF, 16'h0000, 16'h0000, 16'h7777, 16'h00A5};
        vecs[7] = '{1'b0, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h00A5};
        vecs[8] = '{1'b1, 16'h0400, 16'h5555, 16'h0000, 16'h0000, 16'h00A5};
        vecs[9] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 16'h00A5};

        // Reset held two cycles, then an idle stretch with no request.
        repeat (2) @(posedge Clk);
        #1;
        check_output("reset_rdata", mem_rdata, 16'h0);
        check_output("reset_hex", hex_out, 16'h0);
        check_output("reset_ready", mem_ready, 0);
        Reset = 0;
        saw = 0;
        repeat (10) begin
            @(posedge Clk); #1;
            if (mem_ready !== 1'b0) saw = 1;
        end
        check_output("idle_no_ready", saw, 0);

        // Give the low RAM words known contents.
        for (int i = 0; i < 32; i++) begin
            d = 16'($urandom);
            apply_stimulus(0, 1, 16'(i), d, 16'h0, lat, rd, hx);
            model_apply(1, 16'(i), d, 16'h0);
        end

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sw, lat, rd, hx);
            model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sw);
            check_output($sformatf("vec%0d_latency", i), lat, 3);
            check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d_hex", i), hx, vecs[i].exp_hex);
        end

        // Inputs changing during WAIT must not affect the access in flight.
        @(posedge Clk); #1;
        mem_req = 1; mem_we = 0; mem_addr = 16'h0010; mem_wdata = 16'h0;
        @(posedge Clk); #1;
        mem_addr = 16'h0020; mem_we = 1; mem_wdata = 16'hFFFF;
        t = 1;
        while (mem_ready !== 1'b1 && t < 40) begin
            @(posedge Clk); #1; t++;
        end
        mem_req = 0; mem_we = 0;
        model_apply(0, 16'h0010, 16'h0, 16'h0);
        check_output("stable_latency", t, 3);
        check_output("stable_rdata", mem_rdata, rdata_m);
        apply_stimulus(0, 0, 16'h0020, 16'h0, 16'h0, lat, rd, hx);
        model_apply(0, 16'h0020, 16'h0, 16'h0);
        check_output("stable_ram20", rd, rdata_m);

        // Reset in the first WAIT cycle aborts a write.
        apply_stimulus(0, 1, 16'h0008, 16'h1111, 16'h0, lat, rd, hx);
        model_apply(1, 16'h0008, 16'h1111, 16'h0);
        @(posedge Clk); #1;
        mem_req = 1; mem_we = 1; mem_addr = 16'h0008; mem_wdata = 16'hDEAD;
        @(posedge Clk); #1;
        Reset = 1; mem_req = 0; mem_we = 0;
        saw = mem_ready;
        @(posedge Clk); #1;
        Reset = 0;
        saw |= mem_ready;
        repeat (6) begin
            @(posedge Clk); #1;
            saw |= mem_ready;
        end
        rdata_m = 16'h0; hex_m = 16'h0;
        check_output("abort_no_ready", saw, 0);
        check_output("abort_hex", hex_out, 16'h0);
        apply_stimulus(0, 0, 16'h0008, 16'h0, 16'h0, lat, rd, hx);
        model_apply(0, 16'h0008, 16'h0, 16'h0);
        check_output("abort_ram8", rd, 16'h1111);

        // Request held through RESP launches a second transaction at once.
        @(posedge Clk); #1;
        mem_req = 1; mem_we = 0; mem_addr = 16'h0010;
        t = 0; first = -1; second = -1;
        while (t < 40 && second < 0) begin
            @(posedge Clk); #1; t++;
            if (mem_ready === 1'b1) begin
                if (first < 0) first = t; else second = t;
            end
        end
        mem_req = 0;
        model_apply(0, 16'h0010, 16'h0, 16'h0);
        check_output("b2b_first", first, 3);
        check_output("b2b_gap", second - first, 4);
        check_output("b2b_rdata", mem_rdata, rdata_m);

        // Randomized transactions against the model.
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom);
            a = pick_addr();
            d = 16'($urandom);
            s = 16'($urandom);
            apply_stimulus(0, w, a, d, s, lat, rd, hx);
            model_apply(w, a, d, s);
            check_output($sformatf("rnd%0d_latency", i), lat, 3);
            check_output($sformatf("rnd%0d_rdata a=%h we=%0d", i, a, w), rd, rdata_m);
            check_output($sformatf("rnd%0d_hex", i), hx, hex_m);
        end

        // Zero-wait-state instance.
        apply_stimulus(1, 1, 16'h0010, 16'hBEEF, 16'h0, lat, rd, hx);
        check_output("ws0_write_latency", lat, 1);
        apply_stimulus(1, 0, 16'h0010, 16'h0, 16'h0, lat, rd, hx);
        check_output("ws0_read_latency", lat, 1);
        check_output("ws0_read_rdata", rd, 16'hBEEF);
        apply_stimulus(1, 1, 16'hFFFF, 16'h00C3, 16'h0, lat, rd, hx);
        check_output("ws0_hex", hx, 16'h00C3);
        check_output("ws0_write_keeps_rdata", rd, 16'hBEEF);
        apply_stimulus(1, 0, 16'hFFFF, 16'h0, 16'h5A5A, lat, rd, hx);
        check_output("ws0_sw_read", rd, 16'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
